// File: rtl/gate_vector_checker_pkg.sv
// Shared types and helpers for the three-input gate vector checker.
package gate_vector_checker_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int         NUM_VECTORS = 8;
   localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

   // Expected gate response for one input vector: {AND, OR} of the three bits.
   function automatic logic [1:0] expected_resp(input logic [2:0] v);
      return {&v, |v};
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counting settle timer: load starts a hold of SETTLE cycles, expired
// marks the last cycle of that hold.
module settle_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expired
);

   localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

   logic [3:0] settle_cnt;

   // Reload on request, otherwise count down and rest at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= 4'd0;
      end else if (load) begin
         settle_cnt <= RELOAD;
      end else if (settle_cnt != 4'd0) begin
         settle_cnt <= settle_cnt - 4'd1;
      end
   end

   assign expired = (settle_cnt == 4'd0);

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive checker for a three-input AND/OR gate model: walks vectors 0..7,
// holds each for SETTLE cycles, samples the responses and tallies failures.
// Handshake: start is a level request honoured only in IDLE; busy covers every
// DRIVE and SAMPLE cycle; done is a single-cycle pulse while in DONE.
module gate_vector_checker
   import gate_vector_checker_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a_o,
   output logic       b_o,
   output logic       c_o,
   input  logic       d_i,
   input  logic       e_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail,
   output logic       first_fail_vld
);

   state_t     state;
   logic [2:0] vec;
   logic       load;
   logic       expired;
   logic       vec_fail;
   logic [1:0] exp_resp;

   assign exp_resp = expected_resp(vec);
   assign vec_fail = (state == SAMPLE) && ({d_i, e_i} != exp_resp);
   assign load     = ((state == IDLE) && start) ||
                     ((state == SAMPLE) && (vec != LAST_VEC));

   settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .expired (expired)
   );

   // Run sequencer: state, vector index, registered stimulus and result tally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         vec            <= 3'd0;
         {a_o, b_o, c_o} <= 3'b000;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 4'd0;
         first_fail     <= 3'd0;
         first_fail_vld <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state           <= DRIVE;
                  vec             <= 3'd0;
                  {a_o, b_o, c_o} <= 3'b000;
                  busy            <= 1'b1;
                  pass            <= 1'b0;
                  err_count       <= 4'd0;
                  first_fail      <= 3'd0;
                  first_fail_vld  <= 1'b0;
               end
            end
            DRIVE: begin
               if (expired) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (vec_fail) begin
                  err_count <= err_count + 4'd1;
                  if (!first_fail_vld) begin
                     first_fail     <= vec;
                     first_fail_vld <= 1'b1;
                  end
               end
               if (vec != LAST_VEC) begin
                  state           <= DRIVE;
                  vec             <= vec + 3'd1;
                  {a_o, b_o, c_o} <= vec + 3'd1;
               end else begin
                  state           <= DONE;
                  {a_o, b_o, c_o} <= 3'b000;
                  busy            <= 1'b0;
                  done            <= 1'b1;
                  pass            <= (err_count == 4'd0) && !vec_fail;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
